// File: rtl/acc_fpu_arb.sv
// ---------------------------------------------------------------------------
// acc_fpu_arb
//
// Shares a single FPU between two requesters:
//   requester 0 : CPU plain FPU instruction path
//   requester 1 : pivot sequencer
//
// Accepted requests go into a one-entry issue register that drives the FPU
// input handshake. The requester ID is placed in the FPU tag bit TAG_W, so a
// returning result is routed purely from its tag and no reorder logic is
// needed. Per-requester in-flight counters bound outstanding work and let
// the control logic wait for the FPU to drain (busy_o).
//
// Build option:
//   ACC_FPU_ARB_RR_EN  defined   -> round-robin between the two requesters
//                      undefined -> fixed priority, requester 1 wins
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_valid_i[1:0]     request valid per requester
//   req_ready_o[1:0]     grant per requester (combinational)
//   req0_i, req1_i       request payloads; only tag[TAG_W-1:0] is meaningful
//   fpu_in_valid_o       issue register valid
//   fpu_in_ready_i       FPU accepts the issued operation
//   fpu_req_o            issue register contents, tag = {src, tag[TAG_W-1:0]}
//   fpu_out_valid_i      FPU result valid
//   fpu_out_ready_o      always 1
//   fpu_resp_i           FPU result and tag
//   rsp_valid_o[1:0]     result belongs to requester n (combinational)
//   rsp_tag_o            result tag without the requester bit
//   rsp_data_o           result data
//   drain_i              level; blocks all new grants while high
//   busy_o               issue register valid or any op in flight
//   err_o                sticky; response arrived for a requester with no op
//                        in flight
//
// Handshake semantics (all interfaces): a transfer happens in a cycle where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until the transfer. req_ready_o may depend combinationally on
// req_valid_i; fpu_in_valid_o never depends on fpu_in_ready_i.
//
// The FPU tag field must be at least TAG_W+1 bits wide. After a reset the
// FPU has to be flushed as well: results for ops issued before the reset
// find zero counts and raise err_o.
// ---------------------------------------------------------------------------

package acc_fpu_arb_pkg;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FPU_TAG_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        data_t [2:0]          operands;
        logic [3:0]           op;
        logic                 op_mod;
        logic [2:0]           rnd_mode;
        logic [FPU_TAG_W-1:0] tag;
    } fpu_req_t;

    typedef struct packed {
        data_t                result;
        logic [4:0]           status;
        logic [FPU_TAG_W-1:0] tag;
    } fpu_resp_t;
endpackage

module acc_fpu_arb
    import acc_fpu_arb_pkg::*;
#(
    parameter int unsigned TAG_W        = 5,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  fpu_req_t         req0_i,
    input  fpu_req_t         req1_i,
    output logic             fpu_in_valid_o,
    input  logic             fpu_in_ready_i,
    output fpu_req_t         fpu_req_o,
    input  logic             fpu_out_valid_i,
    output logic             fpu_out_ready_o,
    input  fpu_resp_t        fpu_resp_i,
    output logic [1:0]       rsp_valid_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output data_t            rsp_data_o,
    input  logic             drain_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned      CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             issue_v_q, issue_v_d;
    fpu_req_t         issue_req_q, issue_req_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             err_q, err_d;

    logic             reg_free;
    logic             rsp_src;
    logic [1:0]       rsp_hit;
    logic [1:0]       eligible;
    logic [1:0]       grant;

    // Status and the tag bits above the requester bit are not consumed here.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^{fpu_resp_i.tag[FPU_TAG_W-1:TAG_W+1], fpu_resp_i.status};

    // ---------------------------------------------------------------------
    // Response decode
    // ---------------------------------------------------------------------
    assign rsp_src    = fpu_resp_i.tag[TAG_W];
    assign rsp_hit[0] = fpu_out_valid_i && !rsp_src;
    assign rsp_hit[1] = fpu_out_valid_i &&  rsp_src;

    // ---------------------------------------------------------------------
    // Eligibility. The issue register is free if empty or being handed to
    // the FPU this cycle. A response returning this cycle frees a credit
    // immediately, so a requester at its limit can be granted in the same
    // cycle its result comes back. Grants are suppressed during reset.
    // ---------------------------------------------------------------------
    assign reg_free = !issue_v_q || fpu_in_ready_i;

    always_comb begin
        eligible = 2'b00;
        for (int n = 0; n < 2; n++) begin
            eligible[n] = rst_ni && req_valid_i[n] && !drain_i && reg_free &&
                          ((cnt_q[n] < CNT_MAX) || rsp_hit[n]);
        end
    end

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
`ifdef ACC_FPU_ARB_RR_EN
    // last_q holds the most recently granted requester; on contention the
    // other one wins. Reset value 0 gives the first tie to requester 1.
    logic last_q, last_d;

    always_comb begin
        if (eligible == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else begin
            grant = eligible;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant[1]) begin
            last_d = 1'b1;
        end else if (grant[0]) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Pivot sequencer has fixed priority over the CPU path.
    assign grant = {eligible[1], eligible[0] && !eligible[1]};
`endif

    // ---------------------------------------------------------------------
    // Issue register next state
    // ---------------------------------------------------------------------
    always_comb begin
        issue_req_d = grant[1] ? req1_i : req0_i;
        issue_req_d.tag = '0;
        issue_req_d.tag[TAG_W] = grant[1];
        issue_req_d.tag[TAG_W-1:0] = grant[1] ? req1_i.tag[TAG_W-1:0]
                                              : req0_i.tag[TAG_W-1:0];
    end

    always_comb begin
        issue_v_d = issue_v_q;
        if (grant != 2'b00) begin
            issue_v_d = 1'b1;
        end else if (fpu_in_ready_i) begin
            issue_v_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // In-flight counters. Grant and response together cancel; a response
    // with nothing in flight saturates at zero and flags an error.
    // ---------------------------------------------------------------------
    always_comb begin
        err_d = err_q;
        for (int n = 0; n < 2; n++) begin
            cnt_d[n] = cnt_q[n];
            if (rsp_hit[n] && (cnt_q[n] == '0)) begin
                err_d = 1'b1;
            end
            if (grant[n] && !rsp_hit[n]) begin
                cnt_d[n] = cnt_q[n] + CNT_ONE;
            end else if (!grant[n] && rsp_hit[n] && (cnt_q[n] != '0)) begin
                cnt_d[n] = cnt_q[n] - CNT_ONE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            issue_v_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            issue_v_q <= issue_v_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Payload is only meaningful while issue_v_q is set; loaded on grant and
    // otherwise held, which keeps it stable under FPU backpressure.
    always_ff @(posedge clk_i) begin
        if (grant != 2'b00) begin
            issue_req_q <= issue_req_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign req_ready_o     = grant;
    assign fpu_in_valid_o  = issue_v_q;
    assign fpu_req_o       = issue_req_q;
    assign fpu_out_ready_o = 1'b1;
    assign rsp_valid_o     = rsp_hit;
    assign rsp_tag_o       = fpu_resp_i.tag[TAG_W-1:0];
    assign rsp_data_o      = fpu_resp_i.result;
    assign busy_o          = issue_v_q || (cnt_q[0] != '0) || (cnt_q[1] != '0);
    assign err_o           = err_q;

endmodule
